// File: rtl/tag_free_list_pkg.sv
// Shared types and sizing for the rename-stage physical tag free list.
package tag_free_list_pkg;
    localparam int NUM_ISSUE  = 4;
    localparam int NUM_COMMIT = 4;
    localparam int TAG_SIZE   = 7;
    localparam int NUM_TAGS   = 1 << (TAG_SIZE - 1);
    localparam int IDX_W      = TAG_SIZE - 1;

    typedef logic [TAG_SIZE-1:0] Tag;
    typedef logic [IDX_W-1:0]    TagIdx;

    typedef enum logic {
        NORMAL  = 1'b0,
        RECOVER = 1'b1
    } TagFreeListState;

    // Tags with the MSB set name immediates/zero and never occupy a physical slot.
    function automatic logic is_alloc_tag(input Tag t);
        return !t[TAG_SIZE-1];
    endfunction

    function automatic TagIdx tag_idx(input Tag t);
        return t[IDX_W-1:0];
    endfunction
endpackage

// File: rtl/tag_free_list_free_tag_picker.sv
// Finds the first K set bits of a free bitvector, scanning upward from a start
// offset with wrap-around; reports each hit as an absolute index.
module free_tag_picker #(
    parameter int N = 64,
    parameter int K = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] i_free,
    input  logic [W-1:0] i_offset,
    output logic [W-1:0] o_idx   [K],
    output logic [K-1:0] o_valid
);
    logic [N-1:0] w_rotated;

    // Bit j of the rotated view is the tag j places past the offset.
    for (genvar gi = 0; gi < N; gi++) begin : g_rot
        assign w_rotated[gi] = i_free[W'(gi) + i_offset];
    end

    for (genvar gi = 0; gi < K; gi++) begin : g_slot
        logic [N-1:0] w_mask;
        logic [W-1:0] w_pos;
        logic         w_hit;

        if (gi == 0) begin : g_first
            assign w_mask = w_rotated;
        end else begin : g_chain
            assign w_mask = g_slot[gi-1].w_mask & ~(N'(1) << g_slot[gi-1].w_pos);
        end

        always_comb begin
            w_pos = '0;
            w_hit = 1'b0;
            for (int j = N - 1; j >= 0; j--) begin
                if (w_mask[j]) begin
                    w_pos = W'(j);
                    w_hit = 1'b1;
                end
            end
        end

        assign o_idx[gi]   = w_pos + i_offset;
        assign o_valid[gi] = w_hit;
    end
endmodule

// File: rtl/tag_free_list.sv
// Physical tag free list for rename: offers free tags, reclaims on commit, rebuilds after mispredict.
// Optional TAG_FREE_LIST_ROTATE_EN: free-tag search starts at a rotating pointer.
module tag_free_list
    import tag_free_list_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic IN_mispred,
    input  logic IN_mispredFlush,
    input  logic IN_issueValid     [NUM_ISSUE],
    output Tag   OUT_issueTags     [NUM_ISSUE],
    output logic OUT_issueTagValid [NUM_ISSUE],
    input  logic IN_commitValid    [NUM_COMMIT],
    input  logic IN_commitWrites   [NUM_COMMIT],
    input  Tag   IN_commitTags     [NUM_COMMIT],
    input  Tag   IN_commitPrevTags [NUM_COMMIT],
    output Tag   OUT_freeCount,
    output logic OUT_stall
);
    logic [NUM_TAGS-1:0]  r_spec_used;
    logic [NUM_TAGS-1:0]  r_com_used;
    TagFreeListState      r_state;
    Tag                   r_free_count;

    logic [NUM_TAGS-1:0]  w_spec_next;
    logic [NUM_TAGS-1:0]  w_com_next;
    logic [NUM_TAGS-1:0]  w_free;
    TagIdx                w_offset;
    TagIdx                w_pick_idx [NUM_ISSUE];
    logic [NUM_ISSUE-1:0] w_pick_hit;
    logic [NUM_ISSUE-1:0] w_issue_take;
    logic                 w_issue_en;
    logic                 w_commit_en;
    logic                 w_replay_en;

`ifdef TAG_FREE_LIST_ROTATE_EN
    TagIdx r_ptr;
    TagIdx w_ptr_next;
    assign w_offset = r_ptr;
`else
    assign w_offset = '0;
`endif

    assign w_free = ~r_spec_used;

    free_tag_picker #(
        .N (NUM_TAGS),
        .K (NUM_ISSUE),
        .W (IDX_W)
    ) u_picker (
        .i_free   (w_free),
        .i_offset (w_offset),
        .o_idx    (w_pick_idx),
        .o_valid  (w_pick_hit)
    );

    assign OUT_stall     = (r_state == RECOVER);
    assign OUT_freeCount = r_free_count;
    assign w_issue_en    = !IN_mispred && !OUT_stall;
    assign w_commit_en   = !IN_mispredFlush;
    assign w_replay_en   = IN_mispredFlush && !IN_mispred;

    for (genvar gi = 0; gi < NUM_ISSUE; gi++) begin : g_offer
        assign OUT_issueTags[gi]     = {1'b0, w_pick_idx[gi]};
        assign OUT_issueTagValid[gi] = w_pick_hit[gi] && !OUT_stall;
        assign w_issue_take[gi]      = w_issue_en && IN_issueValid[gi] && OUT_issueTagValid[gi];
    end

    // All clears are applied before any set so a same-cycle set of a tag wins.
    always_comb begin
        w_com_next  = r_com_used;
        w_spec_next = r_spec_used;
        for (int c = 0; c < NUM_COMMIT; c++) begin
            if (w_commit_en && IN_commitValid[c] && IN_commitWrites[c]
                    && is_alloc_tag(IN_commitPrevTags[c])) begin
                w_com_next[tag_idx(IN_commitPrevTags[c])]  = 1'b0;
                w_spec_next[tag_idx(IN_commitPrevTags[c])] = 1'b0;
            end
        end
        for (int i = 0; i < NUM_ISSUE; i++) begin
            if (w_issue_take[i]) begin
                w_spec_next[w_pick_idx[i]] = 1'b1;
            end
        end
        for (int c = 0; c < NUM_COMMIT; c++) begin
            if (IN_commitValid[c] && IN_commitWrites[c] && is_alloc_tag(IN_commitTags[c])) begin
                if (w_commit_en) begin
                    w_com_next[tag_idx(IN_commitTags[c])]  = 1'b1;
                    w_spec_next[tag_idx(IN_commitTags[c])] = 1'b1;
                end
                if (w_replay_en) begin
                    w_spec_next[tag_idx(IN_commitTags[c])] = 1'b1;
                end
            end
        end
        if (IN_mispred) begin
            w_spec_next = w_com_next;
        end
    end

`ifdef TAG_FREE_LIST_ROTATE_EN
    // The highest issuing slot holds the furthest tag in wrap order.
    always_comb begin
        w_ptr_next = r_ptr;
        for (int i = 0; i < NUM_ISSUE; i++) begin
            if (w_issue_take[i]) begin
                w_ptr_next = w_pick_idx[i] + TagIdx'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else begin
            r_ptr <= w_ptr_next;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_spec_used  <= '0;
            r_com_used   <= '0;
            r_free_count <= TAG_SIZE'(NUM_TAGS);
            r_state      <= NORMAL;
        end else begin
            r_spec_used  <= w_spec_next;
            r_com_used   <= w_com_next;
            r_free_count <= TAG_SIZE'(NUM_TAGS - $countones(w_spec_next));
            case (r_state)
                NORMAL: begin
                    if (IN_mispred) begin
                        r_state <= RECOVER;
                    end
                end
                RECOVER: begin
                    if (!IN_mispred && !IN_mispredFlush) begin
                        r_state <= NORMAL;
                    end
                end
                default: r_state <= NORMAL;
            endcase
        end
    end

    for (genvar gi = 0; gi < NUM_ISSUE; gi++) begin : g_chk
        a_issue_needs_offer: assert property (@(posedge clk) disable iff (rst)
            (IN_issueValid[gi] && !OUT_stall && !IN_mispred) |-> OUT_issueTagValid[gi]);
    end
endmodule

// File: tb/tb_tag_free_list.sv
// Bench for tag_free_list: directed table, hand-written corner sequences, and
// randomized traffic checked against a set-based reference model.
module tb_tag_free_list;
    import tag_free_list_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mispred, flush;
    logic issue_valid  [NUM_ISSUE];
    Tag   issue_tags   [NUM_ISSUE];
    logic issue_tvalid [NUM_ISSUE];
    logic cvalid  [NUM_COMMIT];
    logic cwrites [NUM_COMMIT];
    Tag   ctags   [NUM_COMMIT];
    Tag   cprev   [NUM_COMMIT];
    Tag   free_count;
    logic stall;

    always #5 clk = ~clk;

    tag_free_list dut (
        .clk               (clk),
        .rst               (rst),
        .IN_mispred        (mispred),
        .IN_mispredFlush   (flush),
        .IN_issueValid     (issue_valid),
        .OUT_issueTags     (issue_tags),
        .OUT_issueTagValid (issue_tvalid),
        .IN_commitValid    (cvalid),
        .IN_commitWrites   (cwrites),
        .IN_commitTags     (ctags),
        .IN_commitPrevTags (cprev),
        .OUT_freeCount     (free_count),
        .OUT_stall         (stall)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: used flags per tag, recovery flag, search start.
    bit m_spec [NUM_TAGS];
    bit m_com  [NUM_TAGS];
    bit m_recover;
    int m_ptr;
    int exp_tag [NUM_ISSUE];
    bit exp_val [NUM_ISSUE];
    int exp_fc;

    typedef struct {
        bit [3:0] iss;
        bit       cv;
        int       ctag;
        int       cprev;
        bit       misp;
        bit       fl;
        int       e_tag0;
        bit [3:0] e_val;
        int       e_fc;
        bit       e_stall;
    } vec_t;

    task automatic chk(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, req);
        end
    endtask

    task automatic model_reset();
        for (int t = 0; t < NUM_TAGS; t++) begin
            m_spec[t] = 1'b0;
            m_com[t]  = 1'b0;
        end
        m_recover = 1'b0;
        m_ptr     = 0;
    endtask

    task automatic compute_expect();
        int q[$];
        int used;
        used = 0;
        for (int n = 0; n < NUM_TAGS; n++) begin
            if (!m_spec[(m_ptr + n) % NUM_TAGS]) q.push_back((m_ptr + n) % NUM_TAGS);
            if (m_spec[n]) used++;
        end
        for (int k = 0; k < NUM_ISSUE; k++) begin
            exp_val[k] = (k < q.size()) && !m_recover;
            exp_tag[k] = (k < q.size()) ? q[k] : 0;
        end
        exp_fc = NUM_TAGS - used;
    endtask

    task automatic model_step();
        bit freed [NUM_TAGS];
        bit claim [NUM_TAGS];
        bit ccom  [NUM_TAGS];
        bit issue_ok, commit_ok, replay_ok;
        int last;
        issue_ok  = !mispred && !m_recover;
        commit_ok = !flush;
        replay_ok = flush && !mispred;
        last = -1;
        for (int t = 0; t < NUM_TAGS; t++) begin
            freed[t] = 1'b0;
            claim[t] = 1'b0;
            ccom[t]  = 1'b0;
        end
        for (int k = 0; k < NUM_ISSUE; k++) begin
            if (issue_ok && issue_valid[k] && exp_val[k]) begin
                claim[exp_tag[k]] = 1'b1;
                last = exp_tag[k];
            end
        end
        for (int c = 0; c < NUM_COMMIT; c++) begin
            if (cvalid[c] && cwrites[c]) begin
                if (commit_ok && int'(cprev[c]) < NUM_TAGS) freed[int'(cprev[c])] = 1'b1;
                if (int'(ctags[c]) < NUM_TAGS && (commit_ok || replay_ok)) claim[int'(ctags[c])] = 1'b1;
                if (int'(ctags[c]) < NUM_TAGS && commit_ok) ccom[int'(ctags[c])] = 1'b1;
            end
        end
        for (int t = 0; t < NUM_TAGS; t++) begin
            m_com[t]  = (m_com[t] && !freed[t]) || ccom[t];
            m_spec[t] = mispred ? m_com[t] : ((m_spec[t] && !freed[t]) || claim[t]);
        end
        if (mispred) m_recover = 1'b1;
        else if (m_recover && !flush) m_recover = 1'b0;
`ifdef TAG_FREE_LIST_ROTATE_EN
        if (last >= 0) m_ptr = (last + 1) % NUM_TAGS;
`endif
    endtask

    task automatic check_all(input string ctx);
        for (int k = 0; k < NUM_ISSUE; k++) begin
            chk($sformatf("%s valid%0d", ctx, k), int'(issue_tvalid[k]), int'(exp_val[k]));
            if (exp_val[k]) chk($sformatf("%s tag%0d", ctx, k), int'(issue_tags[k]), exp_tag[k]);
        end
        chk({ctx, " freeCount"}, int'(free_count), exp_fc);
        chk({ctx, " stall"}, int'(stall), int'(m_recover));
    endtask

    task automatic clear_inputs();
        mispred = 1'b0;
        flush   = 1'b0;
        for (int k = 0; k < NUM_ISSUE; k++) issue_valid[k] = 1'b0;
        for (int c = 0; c < NUM_COMMIT; c++) begin
            cvalid[c]  = 1'b0;
            cwrites[c] = 1'b0;
            ctags[c]   = '0;
            cprev[c]   = '0;
        end
    endtask

    // Inputs are already driven; check current outputs, advance model and DUT.
    task automatic cycle(input string ctx);
        @(negedge clk);
        check_all(ctx);
        model_step();
        @(posedge clk);
        #1;
        compute_expect();
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        compute_expect();
    endtask

    task automatic commit_slot(input int c, input int new_tag, input int prev_tag);
        cvalid[c]  = 1'b1;
        cwrites[c] = 1'b1;
        ctags[c]   = Tag'(new_tag);
        cprev[c]   = Tag'(prev_tag);
    endtask

    function automatic Tag rnd_tag();
        if ($urandom_range(0, 7) == 0) return {1'b1, 6'($urandom_range(0, 63))};
        return {1'b0, 6'($urandom_range(0, 63))};
    endfunction

    initial begin
        vec_t vecs [10];
        clear_inputs();
        do_reset();

        // Reset state against fixed values.
        for (int k = 0; k < NUM_ISSUE; k++) begin
            chk($sformatf("reset tag%0d", k), int'(issue_tags[k]), k);
            chk($sformatf("reset valid%0d", k), int'(issue_tvalid[k]), 1);
        end
        chk("reset freeCount", int'(free_count), 64);
        chk("reset stall", int'(stall), 0);
        $display("seq reset: freeCount=%0d stall=%0d", free_count, stall);

`ifndef TAG_FREE_LIST_ROTATE_EN
        //          iss     cv ctag cprev misp fl  tag0 val     fc  stall
        vecs[0] = '{4'b1111, 0, 0,  0,    0,   0,  4,   4'b1111, 60, 0};
        vecs[1] = '{4'b1111, 0, 0,  0,    0,   0,  8,   4'b1111, 56, 0};
        vecs[2] = '{4'b0000, 1, 0,  64,   0,   0,  8,   4'b1111, 56, 0};
        vecs[3] = '{4'b0000, 1, 1,  64,   0,   0,  8,   4'b1111, 56, 0};
        vecs[4] = '{4'b0000, 0, 0,  0,    1,   0,  -1,  4'b0000, 62, 1};
        vecs[5] = '{4'b0000, 1, 2,  64,   0,   1,  -1,  4'b0000, 61, 1};
        vecs[6] = '{4'b0000, 1, 3,  0,    0,   1,  -1,  4'b0000, 60, 1};
        vecs[7] = '{4'b0000, 0, 0,  0,    0,   0,  4,   4'b1111, 60, 0};
        vecs[8] = '{4'b0101, 0, 0,  0,    0,   0,  5,   4'b1111, 58, 0};
        vecs[9] = '{4'b0000, 1, 4,  2,    0,   0,  2,   4'b1111, 59, 0};
        for (int v = 0; v < 10; v++) begin
            clear_inputs();
            for (int k = 0; k < NUM_ISSUE; k++) issue_valid[k] = vecs[v].iss[k];
            if (vecs[v].cv) commit_slot(0, vecs[v].ctag, vecs[v].cprev);
            mispred = vecs[v].misp;
            flush   = vecs[v].fl;
            cycle($sformatf("vec%0d", v));
            for (int k = 0; k < NUM_ISSUE; k++)
                chk($sformatf("vec%0d tbl valid%0d", v, k), int'(issue_tvalid[k]), int'(vecs[v].e_val[k]));
            if (vecs[v].e_tag0 >= 0) chk($sformatf("vec%0d tbl tag0", v), int'(issue_tags[0]), vecs[v].e_tag0);
            chk($sformatf("vec%0d tbl freeCount", v), int'(free_count), vecs[v].e_fc);
            chk($sformatf("vec%0d tbl stall", v), int'(stall), int'(vecs[v].e_stall));
            $display("vec %0d: tag0=%0d freeCount=%0d stall=%0d", v, issue_tags[0], free_count, stall);
        end
`endif

        // Exhaust every tag, then free one and watch it return alone.
        do_reset();
        for (int n = 0; n < 16; n++) begin
            clear_inputs();
            for (int k = 0; k < NUM_ISSUE; k++) issue_valid[k] = 1'b1;
            cycle("exhaust");
        end
        for (int k = 0; k < NUM_ISSUE; k++) chk($sformatf("empty valid%0d", k), int'(issue_tvalid[k]), 0);
        chk("empty freeCount", int'(free_count), 0);
        $display("seq exhaust: freeCount=%0d", free_count);
        clear_inputs();
        commit_slot(0, 10, 5);
        cycle("free5");
        chk("free5 tag0", int'(issue_tags[0]), 5);
        chk("free5 valid0", int'(issue_tvalid[0]), 1);
        chk("free5 valid1", int'(issue_tvalid[1]), 0);
        chk("free5 freeCount", int'(free_count), 1);
        $display("seq free5: tag0=%0d freeCount=%0d", issue_tags[0], free_count);

        // Same-cycle set of tag 9 in slot 0 and clear of tag 9 in slot 1.
        clear_inputs();
        commit_slot(0, 9, 20);
        commit_slot(1, 30, 9);
        cycle("setclr9");
        chk("setclr9 tag0", int'(issue_tags[0]), 5);
        chk("setclr9 tag1", int'(issue_tags[1]), 20);
        chk("setclr9 valid1", int'(issue_tvalid[1]), 1);
        chk("setclr9 valid2", int'(issue_tvalid[2]), 0);
        chk("setclr9 freeCount", int'(free_count), 2);
        $display("seq setclr9: tag0=%0d tag1=%0d freeCount=%0d", issue_tags[0], issue_tags[1], free_count);

`ifdef TAG_FREE_LIST_ROTATE_EN
        do_reset();
        for (int k = 0; k < NUM_ISSUE; k++) issue_valid[k] = 1'b1;
        cycle("rot issue");
        clear_inputs();
        commit_slot(0, 1, 0);
        cycle("rot free0");
        chk("rot tag0", int'(issue_tags[0]), 4);
        chk("rot tag3", int'(issue_tags[3]), 7);
        chk("rot freeCount", int'(free_count), 61);
        $display("seq rotate: tag0=%0d tag3=%0d", issue_tags[0], issue_tags[3]);
`endif

        // Asynchronous reset in the middle of recovery.
        do_reset();
        for (int k = 0; k < NUM_ISSUE; k++) issue_valid[k] = 1'b1;
        cycle("pre-misp");
        clear_inputs();
        mispred = 1'b1;
        cycle("misp");
        chk("recover stall", int'(stall), 1);
        clear_inputs();
        flush = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        chk("async rst stall", int'(stall), 0);
        chk("async rst freeCount", int'(free_count), 64);
        chk("async rst tag0", int'(issue_tags[0]), 0);
        chk("async rst tag3", int'(issue_tags[3]), 3);
        chk("async rst valid3", int'(issue_tvalid[3]), 1);
        $display("seq async reset: stall=%0d freeCount=%0d", stall, free_count);

        // Randomized traffic against the model.
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            mispred = ($urandom_range(0, 19) == 0);
            flush   = m_recover ? ($urandom_range(0, 3) != 0) : 1'b0;
            for (int k = 0; k < NUM_ISSUE; k++)
                issue_valid[k] = exp_val[k] && ($urandom_range(0, 1) == 1);
            for (int c = 0; c < NUM_COMMIT; c++) begin
                cvalid[c]  = ($urandom_range(0, 1) == 1);
                cwrites[c] = ($urandom_range(0, 3) != 0);
                ctags[c]   = rnd_tag();
                cprev[c]   = rnd_tag();
            end
            cycle($sformatf("rnd%0d", n));
            $display("rnd %0d: misp=%0b flush=%0b freeCount=%0d stall=%0d", n, mispred, flush, free_count, stall);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/tag_free_list.md
# tag_free_list

Physical-tag allocator and reclaimer for the register rename stage. Hands out up to NUM_ISSUE free result tags per cycle to the renamer, frees a destination's previous tag when its overwriting instruction commits, and rebuilds the speculative free set after a branch mispredict while the ROB replays uncommitted pre-branch ops. Sits beside the rename table: consumes its committed previous tags, feeds its issue tag inputs.

## Interface
- NUM_ISSUE, 4, allocation/issue slots per cycle
- NUM_COMMIT, 4, commit slots per cycle
- TAG_SIZE, 7, tag width; MSB set = immediate/zero tag, never allocated or freed
- NUM_TAGS, 1<<(TAG_SIZE-1), allocatable physical tags
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset, asynchronous, active-high
- IN_mispred  in  1  branch mispredict this cycle
- IN_mispredFlush  in  1  ROB replaying pre-branch uncommitted ops
- IN_issueValid[NUM_ISSUE]  in  1  slot i consumes OUT_issueTags[i]
- OUT_issueTags[NUM_ISSUE]  out  TAG_SIZE  offered free tags, MSB 0
- OUT_issueTagValid[NUM_ISSUE]  out  1  offered tag is real
- IN_commitValid[NUM_COMMIT]  in  1  commit slot valid
- IN_commitWrites[NUM_COMMIT]  in  1  op writes a non-zero arch register
- IN_commitTags[NUM_COMMIT]  in  TAG_SIZE  op's result tag
- IN_commitPrevTags[NUM_COMMIT]  in  TAG_SIZE  tag being overwritten (from rename table)
- OUT_freeCount  out  TAG_SIZE  number of free tags (0..NUM_TAGS)
- OUT_stall  out  1  renamer must not issue

## Operation
- State: specUsed[NUM_TAGS], comUsed[NUM_TAGS], FSM {NORMAL, RECOVER}.
- Offer: OUT_issueTags[k] = k-th free tag (lowest index first) in specUsed; OUT_issueTagValid[k]=0 if fewer than k+1 free or OUT_stall. Combinational from registered state.
- Issue: IN_issueValid[i] && OUT_issueTagValid[i] -> specUsed set. Issue with valid offer low is an assertion failure. Issue ignored when IN_mispred or OUT_stall.
- Commit, IN_mispredFlush=0, valid && writes: comUsed[new] set; prevTag (if MSB 0) cleared in specUsed and comUsed. Slot order ascending; a set beats a clear of the same tag in the same cycle.
- Mispredict: specUsed <= comUsed after this cycle's commit updates; FSM -> RECOVER.
- Replay, IN_mispredFlush=1 && !IN_mispred, valid && writes: specUsed[new] set only; nothing freed. Flush together with mispred: commit slots ignored.
- RECOVER: OUT_stall=1; leaves to NORMAL on first cycle with IN_mispredFlush=0 and IN_mispred=0. A new IN_mispred in RECOVER reapplies mispredict, stays RECOVER.
- OUT_freeCount registered: NUM_TAGS - popcount(next specUsed).

## Timing
- Reset (async): specUsed=0, comUsed=0, NORMAL, OUT_stall=0, OUT_freeCount=NUM_TAGS, OUT_issueTags[k]=k, valid all 1.
- Tag freed by commit at cycle t offered at t+1; tag issued at t absent from offers at t+1.
- Mispredict at t: OUT_stall high from t+1 until cycle after flush ends.
- Empty: all valids 0, freeCount 0; partial free: only lowest slots valid.
- Reset asserted mid-recovery returns all state to reset values immediately.

## Configuration
- TAG_FREE_LIST_ROTATE_EN defined: search starts at a rotating pointer (advances past the highest tag issued each cycle, wraps modulo NUM_TAGS); offers are the first free tags at/after the pointer in wrap order. Reset pointer 0.
- Undefined: lowest-index-first search, no pointer register.

## Structure
- Shared package: Tag typedef (TAG_SIZE bits), TagFreeListState enum {NORMAL, RECOVER}, NUM_TAGS constant.
- Sub-module free_tag_picker: N-way find-first-free over a bitvector with start offset (offset tied 0 when rotate disabled).

## Test plan
- Reset, no traffic -> offers 0,1,2,3 valid, freeCount 64, stall 0.
- Issue all 4 slots for 16 cycles -> cycle 16 all valids 0, freeCount 0; commit prevTag 5 -> next cycle slot0 offers 5, others invalid.
- Issue tags 0-3, commit new 0 prev 0x40 (immediate) -> nothing freed, comUsed[0]=1, freeCount 60.
- Issue 0-7, commit 0-1, mispred -> next cycle stall=1; flush replays 2,3 -> after flush ends offers 4,5,6,7, freeCount 60.
- Same-cycle commit set tag 9 and another slot prev 9 -> tag 9 remains used.
- ROTATE_EN: issue 0-3, commit frees 0 -> next offers 4,5,6,7 not 0.
